// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with 3-sample majority vote.
// Ports: clk, rst_n (async low), i_rx_d serial in; o_rx_d/o_rx_valid/i_rx_ready
// handshake; o_parity_error, o_frame_error per frame; o_overrun sticky.
module uart_rx_param #(
    parameter int SYS_CLK   = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int DIVISION  = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx_d,
    output logic [DATA_BITS-1:0] o_rx_d,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_parity_error,
    output logic                 o_frame_error,
    output logic                 o_overrun
);

    localparam int DIV_RAW = SYS_CLK / (BAUD_RATE * DIVISION);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW      = $clog2(DIVISION);
    localparam int BW      = $clog2(DATA_BITS + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [TW-1:0] SMP0     = TW'(DIVISION / 2 - 1);
    localparam logic [TW-1:0] SMP1     = TW'(DIVISION / 2);
    localparam logic [TW-1:0] SMP2     = TW'(DIVISION / 2 + 1);
    localparam logic [TW-1:0] TCK_LAST = TW'(DIVISION - 1);
    localparam logic [BW-1:0] DAT_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [DW-1:0]        div_cnt_q, div_cnt_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 pperr_q, pperr_d;
    logic                 pferr_q, pferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic rx_s, tick, vote_pt, wrap, vote, exp_par, commit, xfer;

    always_comb begin
        sync_d  = {sync_q[0], i_rx_d};
        rx_s    = sync_q[1];
        tick    = (div_cnt_q == DIV_LAST);
        vote_pt = tick && (tick_cnt_q == SMP2);
        wrap    = tick && (tick_cnt_q == TCK_LAST);
        // Third sample is the live line value on the voting tick.
        vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) |
                  (samp_q[1] & rx_s);
        exp_par = (PARITY == 2) ? ~(^shreg_q) : (^shreg_q);
        xfer    = valid_q & i_rx_ready;

        state_d    = state_q;
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        shreg_d    = shreg_q;
        pperr_d    = pperr_q;
        pferr_d    = pferr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        commit     = 1'b0;

        if (tick && tick_cnt_q == SMP0) samp_d[0] = rx_s;
        if (tick && tick_cnt_q == SMP1) samp_d[1] = rx_s;
        if (tick && state_q != ST_IDLE) begin
            tick_cnt_d = wrap ? '0 : tick_cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tick && !rx_s) begin
                    state_d    = ST_START;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shreg_d    = '0;
                    pperr_d    = 1'b0;
                    pferr_d    = 1'b0;
                end
            end
            ST_START: begin
                if (vote_pt && vote) state_d = ST_IDLE;
                else if (wrap)       state_d = ST_DATA;
            end
            ST_DATA: begin
                if (vote_pt) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                if (wrap) begin
                    if (bit_cnt_q == DAT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (vote_pt && (vote != exp_par)) pperr_d = 1'b1;
                if (wrap) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (vote_pt) begin
                    if (!vote) pferr_d = 1'b1;
                    // Leave at the last vote so a back-to-back start is seen.
                    if (bit_cnt_q == STP_LAST) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                        commit    = 1'b1;
                    end
                end else if (wrap) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (xfer) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
        if (commit) begin
            if (!valid_q || xfer) begin
                data_d  = shreg_q;
                perr_d  = pperr_q;
                ferr_d  = pferr_q | ~vote;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sync_q     <= 2'b11;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            shreg_q    <= '0;
            pperr_q    <= 1'b0;
            pferr_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            samp_q     <= samp_d;
            shreg_q    <= shreg_d;
            pperr_q    <= pperr_d;
            pferr_q    <= pferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign o_rx_d         = data_q;
    assign o_rx_valid     = valid_q;
    assign o_parity_error = perr_q;
    assign o_frame_error  = ferr_q;
    assign o_overrun      = ovr_q;

endmodule
